spinner_multi: RTL

Parametrised multi-channel rotary-control encoder for arcade cores. It converts digital left/right inputs (joystick or buttons, optional fast mode) and MiSTer analog spinner deltas into a per-channel W-bit angle and a 2-bit quadrature phase. It replaces a single-channel, frame-stepped spinner in the emu top level. It sits between the hps_io joystick/spinner outputs and the core's input-port mux.

---
 rtl/spinner_multi_if.sv | 25 ++
 rtl/spinner_multi.sv | 120 ++++++++++++
 2 files changed

// File: rtl/spinner_multi_if.sv
// Control inputs and angle/quadrature outputs of the multi-channel spinner.
// master drives requests and spinner words; slave is the encoder.
interface spinner_multi_if #(
    parameter int CH = 2,
    parameter int W  = 4
);
    logic              strobe;
    logic [CH-1:0]     plus;
    logic [CH-1:0]     minus;
    logic [CH-1:0]     fast;
    logic [CH-1:0]     center;
    logic [9*CH-1:0]   spin_in;
    logic [W*CH-1:0]   angle;
    logic [2*CH-1:0]   quad;

    modport master (
        output strobe, plus, minus, fast, center, spin_in,
        input  angle, quad
    );

    modport slave (
        input  strobe, plus, minus, fast, center, spin_in,
        output angle, quad
    );
endinterface

// File: rtl/spinner_multi.sv
// Multi-channel rotary encoder: digital left/right stepping on strobe rising edges plus
// analog spinner deltas drained one step per cycle; angle registered, quad combinational.
module spinner_multi #(
    parameter int CH   = 2,
    parameter int W    = 4,
    parameter int SLOW = 8,
    parameter int FAST = 2,
    parameter int DIV  = 4,
    parameter int MODE = 0
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    spinner_multi_if.slave sp
);
    localparam int PMAX = (SLOW > FAST) ? SLOW : FAST;
    localparam int CW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam logic [W-1:0] ANG_MID = W'(1) << (W-1);
    localparam logic [W-1:0] ANG_RST = (MODE == 1) ? ANG_MID : '0;
    localparam logic signed [W+2:0] ANG_MAX = (W+3)'((1 << W) - 1);
    localparam logic signed [13:0]  DIV_S   = 14'(DIV);
    localparam logic signed [13:0]  ACC_MAX = 14'sd2047;

    logic r_s_q;
    logic w_tick;

    assign w_tick = sp.strobe & ~r_s_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_s_q <= 1'b0;
        else          r_s_q <= sp.strobe;
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [CW-1:0]        r_cnt, w_cnt_eff, w_cnt_nxt, w_lim;
        logic                 r_dir_vld, r_dir, w_vld, w_dir;
        logic signed [11:0]   r_acc, w_acc_nxt;
        logic signed [13:0]   w_acc_ext, w_delta, w_acc_sum;
        logic                 r_tog, r_armed, w_tgl;
        logic [W-1:0]         r_angle, w_angle_nxt;
        logic signed [2:0]    w_d_dig, w_d_an;
        logic signed [W+2:0]  w_ang_sum;

        always_comb begin
            w_vld     = sp.plus[c] ^ sp.minus[c];
            w_dir     = sp.plus[c];
            w_lim     = sp.fast[c] ? CW'(FAST - 1) : CW'(SLOW - 1);
            // A reversal restarts the period, so the first step after it is a full period away.
            w_cnt_eff = (r_dir_vld && w_vld && (r_dir != w_dir)) ? '0 : r_cnt;
            w_cnt_nxt = w_cnt_eff;
            w_d_dig   = 3'sd0;
            if (!w_vld) begin
                w_cnt_nxt = '0;
            end else if (w_tick) begin
                if (w_cnt_eff >= w_lim) begin
                    w_cnt_nxt = '0;
                    w_d_dig   = w_dir ? 3'sd1 : -3'sd1;
                end else begin
                    w_cnt_nxt = w_cnt_eff + CW'(1);
                end
            end
        end

        always_comb begin
            w_tgl     = r_armed && (sp.spin_in[c*9+8] != r_tog);
            w_delta   = {{6{sp.spin_in[c*9+7]}}, sp.spin_in[c*9 +: 8]};
            w_acc_ext = {{2{r_acc[11]}}, r_acc};
            w_acc_sum = w_acc_ext + (w_tgl ? w_delta : 14'sd0);
            w_d_an    = 3'sd0;
            // Step decision looks only at the registered accumulator.
            if (w_acc_ext >= DIV_S) begin
                w_d_an    = 3'sd1;
                w_acc_sum = w_acc_sum - DIV_S;
            end else if (w_acc_ext <= -DIV_S) begin
                w_d_an    = -3'sd1;
                w_acc_sum = w_acc_sum + DIV_S;
            end
            if (w_acc_sum > ACC_MAX)       w_acc_nxt = 12'sd2047;
            else if (w_acc_sum < -ACC_MAX) w_acc_nxt = -12'sd2047;
            else                           w_acc_nxt = w_acc_sum[11:0];
        end

        always_comb begin
            w_ang_sum   = $signed({3'b000, r_angle}) + (W+3)'(w_d_dig) + (W+3)'(w_d_an);
            w_angle_nxt = w_ang_sum[W-1:0];
            if (MODE == 1) begin
                if (w_ang_sum < 0)             w_angle_nxt = '0;
                else if (w_ang_sum > ANG_MAX)  w_angle_nxt = ANG_MAX[W-1:0];
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt     <= '0;
                r_dir_vld <= 1'b0;
                r_dir     <= 1'b0;
                r_acc     <= '0;
                r_tog     <= 1'b0;
                r_armed   <= 1'b0;
                r_angle   <= ANG_RST;
            end else begin
                r_dir_vld <= w_vld;
                r_dir     <= w_dir;
                r_tog     <= sp.spin_in[c*9+8];
                r_armed   <= 1'b1;
                if (sp.center[c]) begin
                    r_cnt   <= '0;
                    r_acc   <= '0;
                    r_angle <= ANG_MID;
                end else begin
                    r_cnt   <= w_cnt_nxt;
                    r_acc   <= w_acc_nxt;
                    r_angle <= w_angle_nxt;
                end
            end
        end

        assign sp.angle[c*W +: W] = r_angle;
        assign sp.quad[c*2 +: 2]  = {r_angle[1], r_angle[1] ^ r_angle[0]};
    end
endmodule
